// File: rtl/branch_ctrl.sv
// PC sequencer: launches branches from execute, resolves them one cycle later against
// the flag_rf condition, redirects and squashes wrong-path fetches, and counts branches.
module branch_ctrl #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_uncond,
  input  logic [PC_W-1:0]  br_target,
  input  logic             cond_true,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             br_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // state   | meaning
  // RUN     | sequential fetch, accepts branch requests
  // RESOLVE | condition from flag_rf is valid, decide taken / not taken
  // FLUSH   | redirected; squash younger stages for FLUSH_CYCLES cycles
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          state;
  logic [PC_W-1:0] tgt_q;
  logic            uncond_q;
  logic [3:0]      flush_cnt;
  logic            taken;

  assign taken = uncond_q | cond_true;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      br_taken    <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
      flush_cnt   <= '0;
      tgt_q       <= '0;
      uncond_q    <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      case (state)
        RUN: begin
          if (!stall) begin
            pc          <= pc + 1'b1;
            fetch_valid <= 1'b1;
            flush       <= 1'b0;
            if (br_valid) begin
              tgt_q    <= br_target;
              uncond_q <= br_uncond;
              state    <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          if (br_count != CNT_MAX) br_count <= br_count + 1'b1;
          if (taken) begin
            pc          <= tgt_q;
            flush       <= 1'b1;
            fetch_valid <= 1'b0;
            br_taken    <= 1'b1;
            flush_cnt   <= FLUSH_LOAD;
            state       <= FLUSH;
            if (taken_count != CNT_MAX) taken_count <= taken_count + 1'b1;
          end else begin
            pc    <= pc + 1'b1;
            state <= RUN;
          end
        end
        FLUSH: begin
          // Terminal count: the decrement that lands on zero also ends the window.
          if (flush_cnt <= 4'd1) begin
            flush_cnt   <= '0;
            flush       <= 1'b0;
            fetch_valid <= 1'b1;
            state       <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state     <= RUN;
          flush     <= 1'b0;
          flush_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_branch_ctrl;
  localparam int          PC_W     = 16;
  localparam logic [15:0] RST_PC   = 16'h0100;
  localparam int          FLUSH_N  = 2;
  localparam int          CNT_W    = 4;
  localparam int          CNT_SAT  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, br_valid, br_uncond, cond_true;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid, flush, br_taken;
  logic [CNT_W-1:0] br_count, taken_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_pc, m_br, m_tc, flush_left;
  bit m_fv, m_fl, m_tk, pend, p_unc;
  int p_tgt;

  branch_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_uncond(br_uncond),
    .br_target(br_target), .cond_true(cond_true), .pc(pc), .fetch_valid(fetch_valid),
    .flush(flush), .br_taken(br_taken), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  function automatic int sat_inc(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  task automatic model_reset();
    m_pc = int'(RST_PC); m_fv = 0; m_fl = 0; m_tk = 0;
    m_br = 0; m_tc = 0; pend = 0; p_unc = 0; p_tgt = 0; flush_left = 0;
  endtask

  // One clock edge of the pipeline-level behaviour.
  task automatic model_edge(input bit s, input bit bv, input bit unc, input int tgt, input bit c);
    m_tk = 0;
    if (pend) begin
      pend = 0;
      m_br = sat_inc(m_br);
      if (p_unc || c) begin
        m_pc = p_tgt; m_tc = sat_inc(m_tc); m_tk = 1;
        m_fl = 1; m_fv = 0; flush_left = FLUSH_N;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end else if (flush_left > 0) begin
      flush_left--;
      if (flush_left == 0) begin m_fl = 0; m_fv = 1; end
    end else if (!s) begin
      m_pc = (m_pc + 1) % 65536;
      m_fv = 1;
      if (bv) begin pend = 1; p_unc = unc; p_tgt = tgt; end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"}, int'(pc), m_pc);
    chk({ctx, ".fetch_valid"}, int'(fetch_valid), int'(m_fv));
    chk({ctx, ".flush"}, int'(flush), int'(m_fl));
    chk({ctx, ".br_taken"}, int'(br_taken), int'(m_tk));
    chk({ctx, ".br_count"}, int'(br_count), m_br);
    chk({ctx, ".taken_count"}, int'(taken_count), m_tc);
  endtask

  task automatic cycle(input string ctx, input bit s, input bit bv, input bit unc,
                       input logic [15:0] tgt, input bit c);
    stall = s; br_valid = bv; br_uncond = unc; br_target = tgt; cond_true = c;
    @(posedge clk);
    model_edge(s, bv, unc, int'(tgt), c);
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Unconditional jump; leaves the DUT in RUN with pc == tgt.
  task automatic jump_to(input logic [15:0] tgt);
    cycle("jmp_req", 0, 1, 1, tgt, 0);
    cycle("jmp_res", 0, 0, 0, 16'h0, 0);
    cycle("jmp_fl1", 0, 0, 0, 16'h0, 0);
    cycle("jmp_fl2", 0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    int bc0, tc0;
    logic [15:0] hold_pc;
    stall = 0; br_valid = 0; br_uncond = 0; br_target = '0; cond_true = 0; rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    chk("t1_reset_pc", int'(pc), 16'h0100);

    for (int i = 1; i <= 4; i++) begin
      cycle("t1_run", 0, 0, 0, 16'h0, 0);
      chk("t1_pc", int'(pc), 16'h0100 + i);
      chk("t1_fv", int'(fetch_valid), 1);
    end

    // taken conditional branch
    jump_to(16'h0010);
    bc0 = int'(br_count); tc0 = int'(taken_count);
    cycle("t2_req", 0, 1, 0, 16'h0040, 0);
    chk("t2_fallthru", int'(pc), 16'h0011);
    cycle("t2_res", 0, 0, 0, 16'h0, 1);
    chk("t2_pc", int'(pc), 16'h0040);
    chk("t2_taken", int'(br_taken), 1);
    chk("t2_flush", int'(flush), 1);
    cycle("t2_fl1", 0, 0, 0, 16'h0, 0);
    chk("t2_flush1", int'(flush), 1);
    cycle("t2_fl2", 0, 0, 0, 16'h0, 0);
    chk("t2_flush_end", int'(flush), 0);
    chk("t2_br_count", int'(br_count), bc0 + 1);
    chk("t2_taken_count", int'(taken_count), tc0 + 1);
    cycle("t2_run", 0, 0, 0, 16'h0, 0);
    chk("t2_resume", int'(pc), 16'h0041);

    // not-taken conditional branch
    jump_to(16'h0010);
    bc0 = int'(br_count); tc0 = int'(taken_count);
    cycle("t3_req", 0, 1, 0, 16'h0040, 0);
    cycle("t3_res", 0, 0, 0, 16'h0, 0);
    chk("t3_pc", int'(pc), 16'h0012);
    chk("t3_flush", int'(flush), 0);
    chk("t3_br_count", int'(br_count), bc0 + 1);
    chk("t3_taken_count", int'(taken_count), tc0);

    // unconditional jump across the wrap point, and plain wrap
    jump_to(16'hFFFE);
    cycle("t4_req", 0, 1, 1, 16'h0000, 0);
    cycle("t4_res", 0, 0, 0, 16'h0, 0);
    chk("t4_pc", int'(pc), 16'h0000);
    chk("t4_taken", int'(br_taken), 1);
    cycle("t4_fl1", 0, 0, 0, 16'h0, 0);
    cycle("t4_fl2", 0, 0, 0, 16'h0, 0);
    jump_to(16'hFFFF);
    cycle("t4_wrap", 0, 0, 0, 16'h0, 0);
    chk("t4_wrap_pc", int'(pc), 16'h0000);

    // branch to its own pc
    jump_to(16'h0200);
    cycle("self_req", 0, 1, 0, 16'h0200, 0);
    cycle("self_res", 0, 0, 0, 16'h0, 1);
    chk("self_pc", int'(pc), 16'h0200);

    // stall with a request in RUN, then stall throughout FLUSH
    cycle("t5_fl1", 0, 0, 0, 16'h0, 0);
    cycle("t5_fl2", 0, 0, 0, 16'h0, 0);
    hold_pc = pc;
    cycle("t5_stall", 1, 1, 1, 16'h0777, 1);
    chk("t5_frozen", int'(pc), int'(hold_pc));
    cycle("t5_nobr", 0, 0, 0, 16'h0, 1);
    chk("t5_nobranch", int'(pc), int'(hold_pc) + 1);
    cycle("t5_req", 0, 1, 1, 16'h0300, 0);
    cycle("t5_res", 1, 1, 0, 16'h0, 0);
    cycle("t5_sfl1", 1, 1, 1, 16'h0555, 1);
    cycle("t5_sfl2", 1, 0, 0, 16'h0, 0);
    chk("t5_flush_done", int'(flush), 0);
    chk("t5_pc", int'(pc), 16'h0300);

    // asynchronous reset in the middle of FLUSH
    cycle("t6_req", 0, 1, 1, 16'h0444, 0);
    cycle("t6_res", 0, 0, 0, 16'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pc", int'(pc), int'(RST_PC));
    chk("t6_async_flush", int'(flush), 0);
    model_reset();
    check_all("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("t6_after", 0, 0, 0, 16'h0, 1);
    chk("t6_after_pc", int'(pc), int'(RST_PC) + 1);

    // drive both counters into saturation
    for (int i = 0; i < CNT_SAT + 3; i++) jump_to(16'(16'h0800 + i));
    chk("sat_br_count", int'(br_count), CNT_SAT);
    chk("sat_taken_count", int'(taken_count), CNT_SAT);

    // randomized traffic from a fresh reset
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit s, bv, unc, c;
      logic [15:0] tgt;
      s   = ($urandom_range(0, 3) == 0);
      bv  = ($urandom_range(0, 9) < 3);
      unc = ($urandom_range(0, 3) == 0);
      c   = $urandom_range(0, 1) == 1;
      tgt = ($urandom_range(0, 7) == 0) ? pc : 16'($urandom);
      cycle("rand", s, bv, unc, tgt, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
